// File: rtl/counter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer_pkg
// Purpose  : Shared definitions for the counter sequencer: FSM state
//            encoding, mode/direction codes and default widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package counter_sequencer_pkg;

    localparam int c_DEF_WIDTH     = 3;
    localparam int c_DEF_LIMIT_RST = 7;

    // Code 2'b11 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic c_MODE_ONESHOT = 1'b0;
    localparam logic c_MODE_LOOP    = 1'b1;
    localparam logic c_DIR_UP       = 1'b0;
    localparam logic c_DIR_DOWN     = 1'b1;

endpackage : counter_sequencer_pkg
`default_nettype wire

// File: rtl/counter_sequencer_core.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer_core
// Purpose  : WIDTH-bit up/down counter register with synchronous load.
//            Load has priority over step; arithmetic wraps modulo 2^WIDTH.
// Ports    : clk    - rising-edge clock
//            clear  - asynchronous active-low reset (q -> 0)
//            ld     - load q from ld_val
//            ld_val - load value
//            step   - count one step in direction dir
//            dir    - 0 = up, 1 = down
//            q      - registered counter value
// Revision : 1.0 - initial release
// ============================================================================
module counter_sequencer_core
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             step,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (step) begin
            r_q <= (dir == c_DIR_DOWN) ? (r_q - c_ONE) : (r_q + c_ONE);
        end
    end

    assign q = r_q;

endmodule : counter_sequencer_core
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer
// Purpose  : Sequencer for a small up/down counter: start/stop, pause,
//            preload with clamping, one-shot or looping operation and a
//            programmable terminal value latched at start.
// Ports    : clk      - rising-edge clock
//            clear    - asynchronous active-low reset
//            start    - IDLE -> RUN request (level, sampled each edge)
//            stop     - abort RUN; dominates start/load in IDLE
//            en       - step enable while running (0 = pause)
//            dir      - 0 = up, 1 = down
//            mode     - 0 = one-shot, 1 = loop
//            load     - preload q in IDLE
//            load_val - preload value
//            limit    - upper bound, latched at start
//            q        - counter value
//            busy     - running
//            tc       - 1-cycle pulse when a step lands on the terminal value
//            done     - 1-cycle completion flag (one-shot)
// Revision : 1.0 - initial release
// ============================================================================
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int LIMIT_RST = c_DEF_LIMIT_RST
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_lim;
    logic             r_tc;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_stepped;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_origin;
    logic             w_ld;
    logic [WIDTH-1:0] w_ld_val;
    logic             w_step;
    logic             w_lim_ld;
    logic             w_tc_set;

    // Terminal/origin follow the live dir input, so a direction change
    // mid-run takes effect on the very next step.
    assign w_term      = (dir == c_DIR_DOWN) ? '0    : r_lim;
    assign w_origin    = (dir == c_DIR_DOWN) ? r_lim : '0;
    assign w_q_stepped = (dir == c_DIR_DOWN) ? (w_q - c_ONE) : (w_q + c_ONE);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_lim   <= WIDTH'(LIMIT_RST);
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tc    <= w_tc_set;
            if (w_lim_ld) begin
                r_lim <= limit;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_ld_val    = w_q;
        w_step      = 1'b0;
        w_lim_ld    = 1'b0;
        w_tc_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!stop) begin
                    if (start) begin
                        // Clamp against the incoming limit so q never
                        // starts beyond the new terminal.
                        w_lim_ld    = 1'b1;
                        w_ld        = 1'b1;
                        w_ld_val    = (w_q < limit) ? w_q : limit;
                        w_state_nxt = S_RUN;
                    end else if (load) begin
                        w_ld     = 1'b1;
                        w_ld_val = (load_val < r_lim) ? load_val : r_lim;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (en) begin
                    if (w_q == w_term) begin
                        if (mode == c_MODE_LOOP) begin
                            w_ld     = 1'b1;
                            w_ld_val = w_origin;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_step = 1'b1;
                        // Landing on terminal flags tc; one-shot finishes on
                        // the same edge so tc and done coincide.
                        if (w_q_stepped == w_term) begin
                            w_tc_set = 1'b1;
                            if (mode == c_MODE_ONESHOT) begin
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    counter_sequencer_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .clear  (clear),
        .ld     (w_ld),
        .ld_val (w_ld_val),
        .step   (w_step),
        .dir    (dir),
        .q      (w_q)
    );

    assign q    = w_q;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign tc   = r_tc;

endmodule : counter_sequencer
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sequencer
// Purpose  : Self-checking bench for counter_sequencer. Stimulus pushes the
//            expected {q,busy,tc,done} after each edge into a scoreboard; a
//            monitor pops and compares on the falling edge.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         clear;
    logic         start, stop, en, dir, mode, load;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] q;
    logic         busy, tc, done;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         tc;
        logic         done;
    } obs_t;

    obs_t  sb[$];
    string nm_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    counter_sequencer #(
        .WIDTH     (W),
        .LIMIT_RST (7)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .q        (q),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic void compare(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got q=%0d busy=%0b tc=%0b done=%0b, expected q=%0d busy=%0b tc=%0b done=%0b",
                     name, got.q, got.busy, got.tc, got.done, exp.q, exp.busy, exp.tc, exp.done);
        end
    endfunction

    // Monitor: the DUT presents a fresh observation every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                obs_t  e;
                string n;
                e = sb.pop_front();
                n = nm_q.pop_front();
                compare(n, obs_t'({q, busy, tc, done}), e);
            end
        end
    end

    // Wait for the next active edge, then record what it must produce.
    task automatic tick(input logic [W-1:0] eq, input logic eb, input logic et,
                        input logic ed, input string name);
        @(posedge clk);
        #1;
        sb.push_back(obs_t'({eq, eb, et, ed}));
        nm_q.push_back(name);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        clear = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; dir = 1'b0;
        mode = 1'b0; load = 1'b0; load_val = '0; limit = '0;
        #2;
        compare("reset_state", obs_t'({q, busy, tc, done}), obs_t'(6'b000_0_0_0));
        @(posedge clk); #1;
        clear = 1'b1;

        // One-shot up to 5
        limit = 3'd5; mode = 1'b0; dir = 1'b0; en = 1'b1; start = 1'b1;
        tick(3'd0, 1'b1, 1'b0, 1'b0, "os_enter_run");
        start = 1'b0;
        tick(3'd1, 1'b1, 1'b0, 1'b0, "os_q1");
        tick(3'd2, 1'b1, 1'b0, 1'b0, "os_q2");
        tick(3'd3, 1'b1, 1'b0, 1'b0, "os_q3");
        tick(3'd4, 1'b1, 1'b0, 1'b0, "os_q4");
        tick(3'd5, 1'b0, 1'b1, 1'b1, "os_q5_tc_done");
        tick(3'd5, 1'b0, 1'b0, 1'b0, "os_idle_hold5");

        // Loop down between 4 and 0
        load = 1'b1; load_val = 3'd2;
        tick(3'd2, 1'b0, 1'b0, 1'b0, "ld_q2");
        load = 1'b0; limit = 3'd4; mode = 1'b1; dir = 1'b1; start = 1'b1;
        tick(3'd2, 1'b1, 1'b0, 1'b0, "lp_enter_run");
        start = 1'b0;
        tick(3'd1, 1'b1, 1'b0, 1'b0, "lp_q1");
        tick(3'd0, 1'b1, 1'b1, 1'b0, "lp_q0_tc");
        tick(3'd4, 1'b1, 1'b0, 1'b0, "lp_wrap4");
        tick(3'd3, 1'b1, 1'b0, 1'b0, "lp_q3");
        tick(3'd2, 1'b1, 1'b0, 1'b0, "lp_q2");
        tick(3'd1, 1'b1, 1'b0, 1'b0, "lp_q1b");
        tick(3'd0, 1'b1, 1'b1, 1'b0, "lp_q0_tc_b");
        tick(3'd4, 1'b1, 1'b0, 1'b0, "lp_wrap4_b");
        tick(3'd3, 1'b1, 1'b0, 1'b0, "lp_q3b");

        // Pause then stop
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick(3'd3, 1'b1, 1'b0, 1'b0, "pause_hold3");
        en = 1'b1; stop = 1'b1;
        tick(3'd3, 1'b0, 1'b0, 1'b0, "stop_to_idle");
        stop = 1'b0;

        // Clamping (lim_r = 4 now)
        load = 1'b1; load_val = 3'd6;
        tick(3'd4, 1'b0, 1'b0, 1'b0, "clamp_load6_lim4");
        load = 1'b0; limit = 3'd2; dir = 1'b0; mode = 1'b0; start = 1'b1;
        tick(3'd2, 1'b1, 1'b0, 1'b0, "clamp_start_lim2");
        start = 1'b0;
        tick(3'd2, 1'b0, 1'b0, 1'b1, "at_term_done_no_tc");
        tick(3'd2, 1'b0, 1'b0, 1'b0, "after_done_idle");

        // Limit 0 one-shot up
        limit = 3'd0; start = 1'b1;
        tick(3'd0, 1'b1, 1'b0, 1'b0, "lim0_enter_run");
        start = 1'b0;
        tick(3'd0, 1'b0, 1'b0, 1'b1, "lim0_done_no_tc");
        tick(3'd0, 1'b0, 1'b0, 1'b0, "lim0_idle");

        // start and stop together in IDLE: nothing happens, load also blocked
        start = 1'b1; stop = 1'b1; load = 1'b1; load_val = 3'd3; limit = 3'd7;
        tick(3'd0, 1'b0, 1'b0, 1'b0, "start_stop_idle");
        tick(3'd0, 1'b0, 1'b0, 1'b0, "start_stop_idle2");
        start = 1'b0; stop = 1'b0; load = 1'b0;

        // Async clear mid-run at q=3
        limit = 3'd7; start = 1'b1;
        tick(3'd0, 1'b1, 1'b0, 1'b0, "rst_run_enter");
        start = 1'b0;
        tick(3'd1, 1'b1, 1'b0, 1'b0, "rst_q1");
        tick(3'd2, 1'b1, 1'b0, 1'b0, "rst_q2");
        tick(3'd3, 1'b1, 1'b0, 1'b0, "rst_q3");
        @(negedge clk); #1;
        clear = 1'b0;
        #1;
        compare("async_clear_midrun", obs_t'({q, busy, tc, done}), obs_t'(6'b000_0_0_0));
        @(posedge clk); #1;
        clear = 1'b1;
        tick(3'd0, 1'b0, 1'b0, 1'b0, "post_clear_idle");
        tick(3'd0, 1'b0, 1'b0, 1'b0, "post_clear_no_pulse");

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_counter_sequencer
`default_nettype wire
